// File: rtl/sect233k1_pkg.sv
// Shared types for the sect233k1 point-multiplier controller.
package sect233k1_pkg;

  localparam int M = 233;

  typedef logic [M-1:0] gf2m_t;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_RESP
  } ctrl_state_t;

endpackage

// File: rtl/sect233k1_req_fifo.sv
// Generic synchronous FIFO. Pointers carry one extra wrap bit so full and
// empty are both distinguishable without a separate count.
module sect233k1_req_fifo #(
  parameter int W     = 233,
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q, rd_q;
  logic         do_push, do_pop;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign dout_o  = mem_q[rd_q[AW-1:0]];

  // Storage write; contents need no reset because the pointers gate reads.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
  end

  // Pointer update; flush shares the reset path.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

endmodule

// File: rtl/sect233k1_pt_mul_ctrl.sv
// Job controller for sect233k1_pt_mul: queues scalars, drives the core's
// clr/start/d handshake one job at a time and returns x/y in request order.
// Optional watchdog: define SECT233K1_PT_MUL_CTRL_WDT_EN.
module sect233k1_pt_mul_ctrl
  import sect233k1_pkg::*;
#(
  parameter int QDepth        = 4,
  parameter int TimeoutCycles = 200000
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  clr,
  input  logic  req_valid,
  output logic  req_ready,
  input  gf2m_t req_d,
  output logic  rsp_valid,
  input  logic  rsp_ready,
  output gf2m_t rsp_d,
  output gf2m_t rsp_x,
  output gf2m_t rsp_y,
  output logic  rsp_err,
  output logic  busy,
  output logic  pm_clr,
  output logic  pm_start,
  output gf2m_t pm_d,
  input  logic  pm_done,
  input  gf2m_t pm_x,
  input  gf2m_t pm_y
);

  ctrl_state_t state_q, state_d;
  gf2m_t       d_q, d_d, x_q, x_d, y_q, y_d;
  logic        err_q, err_d;
  logic        done_q;
  logic        pop, push, full, empty, timeout;
  gf2m_t       head;

  assign push = req_valid && req_ready;

  sect233k1_req_fifo #(.W(M), .DEPTH(QDepth)) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (clr),
    .push_i  (push),
    .din_i   (req_d),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

`ifdef SECT233K1_PT_MUL_CTRL_WDT_EN
  logic [31:0] wdt_q;

  assign timeout = (state_q == ST_WAIT) && (wdt_q == 32'(TimeoutCycles));

  // Watchdog counts cycles spent in WAIT; cleared everywhere else.
  always_ff @(posedge clk) begin
    if (rst || state_q != ST_WAIT) wdt_q <= '0;
    else                           wdt_q <= wdt_q + 32'd1;
  end
`else
  assign timeout = 1'b0;
`endif

  // Next-state and job/result register updates.
  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    x_d     = x_q;
    y_d     = y_q;
    err_d   = err_q;
    pop     = 1'b0;
    case (state_q)
      ST_INIT: state_d = ST_IDLE;
      ST_IDLE: begin
        if (!empty) begin
          pop   = 1'b1;
          d_d   = head;
          x_d   = '0;
          y_d   = '0;
          err_d = 1'b0;
          // Zero scalar yields the point at infinity; the core is skipped.
          state_d = (head == '0) ? ST_RESP : ST_START;
        end
      end
      ST_START: state_d = ST_WAIT;
      ST_WAIT: begin
        // Only a fresh rising edge counts; a done left high is stale.
        if (pm_done && !done_q) begin
          x_d     = pm_x;
          y_d     = pm_y;
          state_d = ST_RESP;
        end else if (timeout) begin
          x_d     = '0;
          y_d     = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_INIT;
    endcase
    if (clr) begin
      state_d = ST_INIT;
      pop     = 1'b0;
    end
  end

  // State and result registers; done_q tracks pm_done for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      d_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      x_q     <= x_d;
      y_q     <= y_d;
      err_q   <= err_d;
      done_q  <= pm_done;
    end
  end

  assign req_ready = !full && (state_q != ST_INIT);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_d     = d_q;
  assign rsp_x     = x_q;
  assign rsp_y     = y_q;
  assign rsp_err   = err_q;
  assign pm_start  = (state_q == ST_START);
  assign pm_d      = pm_start ? d_q : '0;
  // Combinational outputs are held low while reset is asserted.
  assign pm_clr    = !rst && ((state_q == ST_INIT) || timeout);
  assign busy      = !rst && ((state_q != ST_IDLE) || !empty);

endmodule

// File: tb/tb_sect233k1_pt_mul_ctrl.sv
// Directed bench for sect233k1_pt_mul_ctrl with a hand-driven stub core.
module tb_sect233k1_pt_mul_ctrl;
  import sect233k1_pkg::*;

  localparam gf2m_t KX = 233'h17232ba853a7e731af129f22ff4149563a419c26bf50a4c9d6eefad6126;
  localparam gf2m_t KY = 233'h1db537dece819b7f70f555a67c427a8cd9bf18aeb9b56e0c11056fae6a3;

  logic  clk = 1'b0, rst = 1'b1, clr = 1'b0;
  logic  req_valid = 1'b0, rsp_ready = 1'b0, pm_done = 1'b0;
  gf2m_t req_d = '0, pm_x = '0, pm_y = '0;
  logic  req_ready, rsp_valid, rsp_err, busy, pm_clr, pm_start;
  gf2m_t rsp_d, rsp_x, rsp_y, pm_d;

  int    tests = 0, fails = 0;
  int    start_cnt = 0, clrp_cnt = 0, exp_starts = 0;
  gf2m_t last_pm_d = '0;

  sect233k1_pt_mul_ctrl #(.QDepth(4), .TimeoutCycles(50)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .req_valid(req_valid), .req_ready(req_ready), .req_d(req_d),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_d(rsp_d),
    .rsp_x(rsp_x), .rsp_y(rsp_y), .rsp_err(rsp_err), .busy(busy),
    .pm_clr(pm_clr), .pm_start(pm_start), .pm_d(pm_d),
    .pm_done(pm_done), .pm_x(pm_x), .pm_y(pm_y)
  );

  always #5 clk = ~clk;

  // Counts core-side pulses mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (pm_start) begin
      start_cnt <= start_cnt + 1;
      last_pm_d <= pm_d;
    end
    if (pm_clr) clrp_cnt <= clrp_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input gf2m_t obs, input gf2m_t exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic push1(input gf2m_t d);
    req_valid = 1'b1;
    req_d = d;
    tick();
    req_valid = 1'b0;
  endtask

  // Bounded wait for the next pm_start; leaves the DUT in WAIT.
  task automatic wait_start(input gf2m_t d);
    int k = 0;
    while (start_cnt <= exp_starts && k < 40) begin
      tick();
      k++;
    end
    exp_starts++;
    chk("start_count", gf2m_t'(start_cnt), gf2m_t'(exp_starts));
    chk("pm_d", last_pm_d, d);
  endtask

  task automatic run_job(input gf2m_t d);
    wait_start(d);
    pm_done = 1'b1;
    pm_x = d ^ KX;
    pm_y = d ^ KY;
    tick();
    chkb("rsp_valid", rsp_valid, 1'b1);
    chk("rsp_d", rsp_d, d);
    chk("rsp_x", rsp_x, d ^ KX);
    chk("rsp_y", rsp_y, d ^ KY);
    chkb("rsp_err", rsp_err, 1'b0);
    pm_done = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chkb("rsp_drop", rsp_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit stable;
    int n;
    int c0;

    // Reset: everything quiet while rst is held.
    tick(); tick();
    chkb("rst_req_ready", req_ready, 1'b0);
    chkb("rst_rsp_valid", rsp_valid, 1'b0);
    chkb("rst_pm_clr", pm_clr, 1'b0);
    chkb("rst_busy", busy, 1'b0);
    chkb("rst_pm_start", pm_start, 1'b0);
    rst = 1'b0;
    #1;
    chkb("init_pm_clr", pm_clr, 1'b1);
    chkb("init_req_ready", req_ready, 1'b0);
    tick();
    chkb("idle_pm_clr", pm_clr, 1'b0);
    chkb("idle_req_ready", req_ready, 1'b1);
    chkb("idle_busy", busy, 1'b0);

    // First job d=1: pop-to-start latency and pm_d gating.
    push1(233'd1);
    chkb("queued_busy", busy, 1'b1);
    tick();
    chkb("start_pulse", pm_start, 1'b1);
    chk("start_pm_d", pm_d, 233'd1);
    tick();
    exp_starts++;
    chkb("wait_no_start", pm_start, 1'b0);
    chk("wait_pm_d_zero", pm_d, '0);
    pm_done = 1'b1;
    pm_x = KX;
    pm_y = KY;
    tick();
    pm_done = 1'b0;
    pm_x = '0;
    pm_y = '0;
    chkb("d1_rsp_valid", rsp_valid, 1'b1);
    chk("d1_rsp_x", rsp_x, KX);
    chk("d1_rsp_y", rsp_y, KY);
    chk("d1_rsp_d", rsp_d, 233'd1);
    chkb("d1_rsp_err", rsp_err, 1'b0);

    // Back-pressure: hold the response 100 cycles with another job queued.
    push1(233'd7);
    stable = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (!rsp_valid || rsp_x !== KX || rsp_y !== KY || rsp_d !== 233'd1) stable = 1'b0;
      tick();
    end
    chkb("hold_stable", stable, 1'b1);
    chk("hold_no_start", gf2m_t'(start_cnt), gf2m_t'(exp_starts));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chkb("hold_released", rsp_valid, 1'b0);
    run_job(233'd7);

    // Back-to-back d=1..5: ready drops once four entries are waiting.
    for (int i = 1; i <= 5; i++) begin
      req_valid = 1'b1;
      req_d = gf2m_t'(i);
      chkb("b2b_ready", req_ready, 1'b1);
      tick();
    end
    req_valid = 1'b0;
    chkb("b2b_full", req_ready, 1'b0);
    for (int i = 1; i <= 5; i++) run_job(gf2m_t'(i));
    chk("b2b_starts", gf2m_t'(start_cnt), gf2m_t'(exp_starts));

    // Zero scalar: no core activity, response one cycle after pop.
    push1('0);
    tick();
    chkb("zero_rsp_valid", rsp_valid, 1'b1);
    chk("zero_rsp_x", rsp_x, '0);
    chk("zero_rsp_y", rsp_y, '0);
    chk("zero_rsp_d", rsp_d, '0);
    chk("zero_no_start", gf2m_t'(start_cnt), gf2m_t'(exp_starts));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Soft clear during WAIT with a second job pending; late done ignored.
    push1(233'd9);
    push1(233'd10);
    wait_start(233'd9);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chkb("clr_pm_clr", pm_clr, 1'b1);
    chkb("clr_rsp_valid", rsp_valid, 1'b0);
    tick(); tick();
    pm_done = 1'b1;
    pm_x = KX;
    pm_y = KY;
    stable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (rsp_valid) stable = 1'b0;
    end
    chkb("clr_no_rsp", stable, 1'b1);
    chkb("clr_busy", busy, 1'b0);
    chkb("clr_ready", req_ready, 1'b1);
    chk("clr_no_start", gf2m_t'(start_cnt), gf2m_t'(exp_starts));

    // Stale done: pm_done already high on WAIT entry must not complete.
    push1(233'd11);
    wait_start(233'd11);
    tick(); tick(); tick();
    chkb("stale_no_rsp", rsp_valid, 1'b0);
    pm_done = 1'b0;
    tick();
    pm_done = 1'b1;
    pm_x = 233'h5A;
    pm_y = 233'hC3;
    tick();
    chkb("stale_rsp_valid", rsp_valid, 1'b1);
    chk("stale_rsp_x", rsp_x, 233'h5A);
    chk("stale_rsp_y", rsp_y, 233'hC3);
    pm_done = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Reset with a response pending clears the result registers.
    push1(233'd12);
    run_job(233'd12);
    push1(233'd13);
    wait_start(233'd13);
    pm_done = 1'b1;
    pm_x = KY;
    tick();
    chkb("rstmid_rsp_valid", rsp_valid, 1'b1);
    rst = 1'b1;
    pm_done = 1'b0;
    tick();
    chkb("rstmid_valid", rsp_valid, 1'b0);
    chk("rstmid_x", rsp_x, '0);
    chk("rstmid_d", rsp_d, '0);
    rst = 1'b0;
    tick();
    chkb("rstmid_ready", req_ready, 1'b1);

`ifdef SECT233K1_PT_MUL_CTRL_WDT_EN
    // Watchdog: core never finishes; error response 52 cycles after start.
    push1(233'd14);
    n = 0;
    while (!pm_start && n < 20) begin
      tick();
      n++;
    end
    chkb("wdt_started", pm_start, 1'b1);
    c0 = clrp_cnt;
    n = 0;
    while (!rsp_valid && n < 100) begin
      tick();
      n++;
    end
    chk("wdt_latency", gf2m_t'(n), gf2m_t'(52));
    chkb("wdt_err", rsp_err, 1'b1);
    chk("wdt_x", rsp_x, '0);
    chk("wdt_y", rsp_y, '0);
    chk("wdt_d", rsp_d, 233'd14);
    chk("wdt_clr_pulse", gf2m_t'(clrp_cnt), gf2m_t'(c0 + 1));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
`else
    n = 0;
    c0 = 0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
